// File: rtl/cache_param_wb.sv
// cache_param_wb: direct-mapped, write-back, write-allocate cache.
//
// Requests from the processor are accepted one at a time. A miss goes to
// memory one word at a time. A dirty victim line is written back first,
// then the new line is refilled. A flush request writes back every dirty
// line. The lines stay valid after the flush.
//
// Parameters
//   p_num_sets    number of sets (power of 2, >= 2)
//   p_line_words  32-bit words per line (power of 2, >= 1)
//
// Ports
//   clk, reset                       rising-edge clock; async active-low reset
//   cachereq_val/rdy/type/addr/data  processor request (type 0=read, 1=write)
//   cacheresp_val/rdy/data           processor response (data is 0 for writes)
//   memreq_val/rdy/type/addr/data    memory request, one word per request
//   memresp_val/rdy/data             memory response
//   flush, flush_done                flush request; one-cycle done pulse
//   hit_count, miss_count            hit/miss statistics
//
// Configuration macro
//   CACHE_PARAM_WB_STATS_EN  when defined, hit_count/miss_count count the
//                            hits and misses seen at tag check. When it is
//                            not defined, both outputs are tied to 0.
module cache_param_wb #(
    parameter int p_num_sets   = 16,
    parameter int p_line_words = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cachereq_val,
    output logic        cachereq_rdy,
    input  logic        cachereq_type,
    input  logic [31:0] cachereq_addr,
    input  logic [31:0] cachereq_data,
    output logic        cacheresp_val,
    input  logic        cacheresp_rdy,
    output logic [31:0] cacheresp_data,
    output logic        memreq_val,
    input  logic        memreq_rdy,
    output logic        memreq_type,
    output logic [31:0] memreq_addr,
    output logic [31:0] memreq_data,
    input  logic        memresp_val,
    output logic        memresp_rdy,
    input  logic [31:0] memresp_data,
    input  logic        flush,
    output logic        flush_done,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX_W = $clog2(p_num_sets);
    localparam int WRD_W = (p_line_words > 1) ? $clog2(p_line_words) : 1;
    localparam int OFF_W = $clog2(p_line_words) + 2;
    localparam int TAG_W = 32 - OFF_W - IDX_W;

    typedef enum logic [3:0] {
        IDLE, TAG_CHECK, EVICT_REQ, EVICT_RESP, REFILL_REQ,
        REFILL_RESP, ACCESS, WAIT, FLUSH_SCAN, FLUSH_DONE
    } state_t;

    state_t                 state, state_next;
    logic                   req_type;
    logic [31:0]            req_addr;
    logic [31:0]            req_data;
    logic [IDX_W-1:0]       cur_idx;      // set being accessed, evicted or scanned
    logic [WRD_W-1:0]       word_cnt;     // word of the current line transfer
    logic                   flushing;     // eviction belongs to a flush
    logic [31:0]            resp_data;
    logic [p_num_sets-1:0]  valid;
    logic [p_num_sets-1:0]  dirty;
    logic [TAG_W-1:0]       tags     [p_num_sets];
    logic [31:0]            data_mem [p_num_sets][p_line_words];

    logic [TAG_W-1:0]       req_tag;
    logic [WRD_W-1:0]       req_word;
    logic                   hit;
    logic                   last_word;
    logic                   last_set;

    assign req_tag   = TAG_W'(req_addr >> (OFF_W + IDX_W));
    assign req_word  = WRD_W'((req_addr >> 2) & 32'(p_line_words - 1));
    assign hit       = valid[cur_idx] && (tags[cur_idx] == req_tag);
    assign last_word = (word_cnt == WRD_W'(p_line_words - 1));
    assign last_set  = (cur_idx == IDX_W'(p_num_sets - 1));

    // NOTE: state-holding logic uses non-blocking assignments so that every
    // register samples values from before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: the default at the top of the block means that every path
    // assigns state_next, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:        if (flush)             state_next = FLUSH_SCAN;
                         else if (cachereq_val) state_next = TAG_CHECK;
            TAG_CHECK:   if (hit)               state_next = WAIT;
                         else if (valid[cur_idx] && dirty[cur_idx])
                                                state_next = EVICT_REQ;
                         else                   state_next = REFILL_REQ;
            EVICT_REQ:   if (memreq_rdy)        state_next = EVICT_RESP;
            EVICT_RESP:  if (memresp_val) begin
                             if (!last_word)    state_next = EVICT_REQ;
                             else if (!flushing) state_next = REFILL_REQ;
                             else if (last_set) state_next = FLUSH_DONE;
                             else               state_next = FLUSH_SCAN;
                         end
            REFILL_REQ:  if (memreq_rdy)        state_next = REFILL_RESP;
            REFILL_RESP: if (memresp_val)       state_next = last_word ? ACCESS : REFILL_REQ;
            ACCESS:                             state_next = WAIT;
            WAIT:        if (cacheresp_rdy)     state_next = IDLE;
            FLUSH_SCAN:  if (dirty[cur_idx])    state_next = EVICT_REQ;
                         else if (last_set)     state_next = FLUSH_DONE;
            FLUSH_DONE:                         state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // Control registers and line status bits. All of them are reset, so the
    // cache comes out of reset with no valid or dirty lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_type  <= 1'b0;
            req_addr  <= '0;
            req_data  <= '0;
            cur_idx   <= '0;
            word_cnt  <= '0;
            flushing  <= 1'b0;
            resp_data <= '0;
            valid     <= '0;
            dirty     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush) begin
                        flushing <= 1'b1;
                        cur_idx  <= '0;
                    end else if (cachereq_val) begin
                        req_type <= cachereq_type;
                        req_addr <= cachereq_addr;
                        req_data <= cachereq_data;
                        cur_idx  <= cachereq_addr[OFF_W +: IDX_W];
                    end
                end
                TAG_CHECK: begin
                    if (hit) begin
                        resp_data <= req_type ? '0 : data_mem[cur_idx][req_word];
                        if (req_type) dirty[cur_idx] <= 1'b1;
                    end
                end
                EVICT_RESP: begin
                    if (memresp_val) begin
                        // Each transfer that completes returns word_cnt to 0.
                        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
                        if (last_word && flushing) begin
                            dirty[cur_idx] <= 1'b0;
                            cur_idx        <= cur_idx + 1'b1;
                        end
                    end
                end
                REFILL_RESP: begin
                    if (memresp_val) begin
                        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
                        if (last_word) begin
                            valid[cur_idx] <= 1'b1;
                            dirty[cur_idx] <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    resp_data <= req_type ? '0 : data_mem[cur_idx][req_word];
                    if (req_type) dirty[cur_idx] <= 1'b1;
                end
                FLUSH_SCAN: if (!dirty[cur_idx]) cur_idx <= cur_idx + 1'b1;
                FLUSH_DONE: flushing <= 1'b0;
                default: ;
            endcase
        end
    end

    // NOTE: tags and data are storage arrays. They are left out of reset
    // because the valid bits already say whether their contents mean anything.
    always_ff @(posedge clk) begin
        if ((state == TAG_CHECK && hit && req_type) || (state == ACCESS && req_type))
            data_mem[cur_idx][req_word] <= req_data;
        if (state == REFILL_RESP && memresp_val) begin
            data_mem[cur_idx][word_cnt] <= memresp_data;
            if (last_word) tags[cur_idx] <= req_tag;
        end
    end

    // The cache is not ready while reset is held, even though state is IDLE.
    assign cachereq_rdy   = reset && (state == IDLE) && !flush;
    assign cacheresp_val  = (state == WAIT);
    assign cacheresp_data = resp_data;
    assign memreq_val     = (state == EVICT_REQ) || (state == REFILL_REQ);
    assign memreq_type    = (state == EVICT_REQ);
    assign memresp_rdy    = (state == EVICT_RESP) || (state == REFILL_RESP);
    assign flush_done     = (state == FLUSH_DONE);

    always_comb begin
        memreq_addr = '0;
        memreq_data = '0;
        if (state == EVICT_REQ) begin
            memreq_addr = (32'(tags[cur_idx]) << (OFF_W + IDX_W)) |
                          (32'(cur_idx) << OFF_W) | (32'(word_cnt) << 2);
            memreq_data = data_mem[cur_idx][word_cnt];
        end else if (state == REFILL_REQ) begin
            memreq_addr = (32'(req_tag) << (OFF_W + IDX_W)) |
                          (32'(cur_idx) << OFF_W) | (32'(word_cnt) << 2);
        end
    end

`ifdef CACHE_PARAM_WB_STATS_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state == TAG_CHECK) begin
            if (hit) hit_q  <= hit_q + 32'd1;
            else     miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_param_wb.sv
// tb_cache_param_wb: self-checking bench for cache_param_wb (default params).
// A behavioural model treats the cache as transparent storage. A read
// returns the last value written to that address. Line residency gives the
// expected hit/miss and memory traffic. A simple memory with random
// handshake delays plays the memory side.
module tb_cache_param_wb;

    localparam int NS = 16;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cachereq_val = 1'b0, cachereq_rdy, cachereq_type = 1'b0;
    logic [31:0] cachereq_addr = '0, cachereq_data = '0;
    logic        cacheresp_val, cacheresp_rdy = 1'b0;
    logic [31:0] cacheresp_data;
    logic        memreq_val, memreq_rdy, memreq_type;
    logic [31:0] memreq_addr, memreq_data;
    logic        memresp_val, memresp_rdy;
    logic [31:0] memresp_data;
    logic        flush = 1'b0, flush_done;
    logic [31:0] hit_count, miss_count;

    always #5 clk = ~clk;

    cache_param_wb #(.p_num_sets(NS), .p_line_words(LW)) dut (
        .clk(clk), .reset(reset),
        .cachereq_val(cachereq_val), .cachereq_rdy(cachereq_rdy),
        .cachereq_type(cachereq_type), .cachereq_addr(cachereq_addr),
        .cachereq_data(cachereq_data),
        .cacheresp_val(cacheresp_val), .cacheresp_rdy(cacheresp_rdy),
        .cacheresp_data(cacheresp_data),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
        .memreq_addr(memreq_addr), .memreq_data(memreq_data),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_data(memresp_data),
        .flush(flush), .flush_done(flush_done),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct {
        logic        typ;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        log_q[$];                 // memory traffic as seen by the memory
    txn_t        exp_q[$];                 // memory traffic the model predicts
    logic [31:0] bmem   [logic [31:0]];    // backing memory contents
    logic [31:0] shadow [logic [31:0]];    // architectural value of each word

    // Model of which line each set holds.
    bit          m_valid [NS];
    bit          m_dirty [NS];
    logic [31:0] m_tag   [NS];
    int          m_hit = 0, m_miss = 0;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] shadow_read(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    bit          pending = 0;
    logic        pend_typ;
    logic [31:0] pend_addr;
    txn_t        rtx;

    initial begin
        memreq_rdy   = 1'b0;
        memresp_val  = 1'b0;
        memresp_data = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pending = 0;
            end else if (!pending && memreq_val) begin
                if ($urandom_range(0, 3) != 0) begin
                    rtx.typ  = memreq_type;
                    rtx.addr = memreq_addr;
                    rtx.data = memreq_type ? memreq_data : 32'h0;
                    memreq_rdy = 1'b1;
                    @(posedge clk);
                    #1 memreq_rdy = 1'b0;
                    if (reset) begin
                        log_q.push_back(rtx);
                        if (rtx.typ) bmem[rtx.addr] = rtx.data;
                        pending   = 1;
                        pend_typ  = rtx.typ;
                        pend_addr = rtx.addr;
                    end
                end
            end else if (pending && memresp_rdy) begin
                if ($urandom_range(0, 3) != 0) begin
                    memresp_val  = 1'b1;
                    memresp_data = pend_typ ? 32'h0 : mem_read(pend_addr);
                    @(posedge clk);
                    #1 memresp_val = 1'b0;
                    memresp_data = '0;
                    pending = 0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        m_hit  = 0;
        m_miss = 0;
    endtask

    task automatic model_access(input logic typ, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] exp_rd, output bit hit);
        int          idx;
        logic [31:0] tag, base, wa;
        idx  = int'((a >> 4) % NS);
        tag  = a >> 8;
        base = a & ~32'hF;
        wa   = a & ~32'h3;
        hit  = m_valid[idx] && (m_tag[idx] == tag);
        if (hit) begin
            m_hit++;
        end else begin
            m_miss++;
            if (m_valid[idx] && m_dirty[idx])
                for (int w = 0; w < LW; w++) begin
                    logic [31:0] va;
                    va = (m_tag[idx] << 8) | (32'(idx) << 4) | (32'(w) << 2);
                    exp_q.push_back('{1'b1, va, shadow_read(va)});
                end
            for (int w = 0; w < LW; w++)
                exp_q.push_back('{1'b0, base + 32'(4 * w), 32'h0});
            m_valid[idx] = 1;
            m_tag[idx]   = tag;
            m_dirty[idx] = 0;
        end
        if (typ) begin
            shadow[wa]   = d;
            m_dirty[idx] = 1;
            exp_rd       = 32'h0;
        end else begin
            exp_rd = shadow_read(wa);
        end
    endtask

    task automatic model_flush();
        for (int idx = 0; idx < NS; idx++)
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int w = 0; w < LW; w++) begin
                    logic [31:0] va;
                    va = (m_tag[idx] << 8) | (32'(idx) << 4) | (32'(w) << 2);
                    exp_q.push_back('{1'b1, va, shadow_read(va)});
                end
                m_dirty[idx] = 0;
            end
    endtask

    task automatic compare_txns(input string name);
        check($sformatf("%s txn count", name), log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("%s txn%0d type", name, i), log_q[i].typ,  exp_q[i].typ);
            check($sformatf("%s txn%0d addr", name, i), log_q[i].addr, exp_q[i].addr);
            check($sformatf("%s txn%0d data", name, i), log_q[i].data, exp_q[i].data);
        end
    endtask

    // ---------------- processor side ----------------
    task automatic cpu_drive(input logic typ, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cachereq_val  = 1'b1;
        cachereq_type = typ;
        cachereq_addr = a;
        cachereq_data = d;
    endtask

    // Waits for acceptance and then for the response. The response is held
    // for `hold` extra cycles with a stray request pending.
    task automatic cpu_complete(input int hold, input logic [31:0] exp_rd,
                                output logic [31:0] rd, output int lat, output bit ok);
        int n = 0;
        ok  = 0;
        rd  = '0;
        lat = 0;
        while (!cachereq_rdy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cachereq_rdy) begin
            cachereq_val = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cachereq_val = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cacheresp_val && lat < 2000);
        if (!cacheresp_val) return;
        ok = 1;
        rd = cacheresp_data;
        for (int i = 0; i < hold; i++) begin
            cachereq_val  = 1'b1;
            cachereq_addr = 32'h0000_0F00;
            check($sformatf("hold%0d resp_val", i),  cacheresp_val,  1'b1);
            check($sformatf("hold%0d resp_data", i), cacheresp_data, exp_rd);
            check($sformatf("hold%0d req_rdy", i),   cachereq_rdy,   1'b0);
            @(negedge clk);
        end
        cachereq_val  = 1'b0;
        cacheresp_rdy = 1'b1;
        @(posedge clk);
        #1 cacheresp_rdy = 1'b0;
    endtask

    task automatic do_access(input logic typ, input logic [31:0] a, input logic [31:0] d,
                             input int hold, input string name);
        logic [31:0] exp_rd, rd;
        bit          hit, ok;
        int          lat;
        log_q.delete();
        exp_q.delete();
        model_access(typ, a, d, exp_rd, hit);
        cpu_drive(typ, a, d);
        cpu_complete(hold, exp_rd, rd, lat, ok);
        check({name, " responded"}, ok, 1'b1);
        check({name, " data"}, rd, exp_rd);
        if (hit) check({name, " hit latency"}, lat, 2);
        compare_txns(name);
    endtask

    task automatic do_flush(input bit with_req, input logic [31:0] a, input string name);
        int          pulses = 0, n = 0, lat;
        logic [31:0] exp_rd, rd;
        bit          hit, ok;
        log_q.delete();
        exp_q.delete();
        model_flush();
        @(negedge clk);
        flush         = 1'b1;
        cachereq_val  = with_req;
        cachereq_type = 1'b0;
        cachereq_addr = a;
        #1 check({name, " rdy low while flush"}, cachereq_rdy, 1'b0);
        @(posedge clk);
        #1 flush = 1'b0;
        while (!cachereq_rdy && n < 2000) begin
            @(negedge clk);
            if (flush_done) pulses++;
            n++;
        end
        check({name, " done pulses"}, pulses, 1);
        check({name, " back to idle"}, cachereq_rdy, 1'b1);
        compare_txns(name);
        if (with_req) begin
            log_q.delete();
            exp_q.delete();
            model_access(1'b0, a, 32'h0, exp_rd, hit);
            cpu_complete(0, exp_rd, rd, lat, ok);
            check({name, " req responded"}, ok, 1'b1);
            check({name, " req data"}, rd, exp_rd);
            compare_txns({name, " req"});
        end
    endtask

    task automatic check_stats(input string name);
`ifdef CACHE_PARAM_WB_STATS_EN
        check({name, " hit_count"},  hit_count,  32'(m_hit));
        check({name, " miss_count"}, miss_count, 32'(m_miss));
`else
        check({name, " hit_count"},  hit_count,  32'h0);
        check({name, " miss_count"}, miss_count, 32'h0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] a;
        model_reset();

        // Values while reset is held.
        repeat (3) @(negedge clk);
        check("rst cachereq_rdy",   cachereq_rdy,   1'b0);
        check("rst cacheresp_val",  cacheresp_val,  1'b0);
        check("rst memreq_val",     memreq_val,     1'b0);
        check("rst memresp_rdy",    memresp_rdy,    1'b0);
        check("rst flush_done",     flush_done,     1'b0);
        check("rst memreq_addr",    memreq_addr,    32'h0);
        check("rst cacheresp_data", cacheresp_data, 32'h0);
        check("rst hit_count",      hit_count,      32'h0);
        check("rst miss_count",     miss_count,     32'h0);
        reset = 1'b1;
        #1 check("ready after reset", cachereq_rdy, 1'b1);

        // Write-allocate miss, then a read hit of the same word.
        do_access(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, "wr 1000");
        do_access(1'b0, 32'h0000_1000, 32'h0, 0, "rd 1000");
        // Dirty victim in the same set: write back 0x1000 line, then refill 0x2000.
        do_access(1'b0, 32'h0000_2000, 32'h0, 0, "rd 2000");
        check("evict first addr", (log_q.size() > 0) ? log_q[0].addr : 32'hFFFF_FFFF, 32'h0000_1000);
        check("refill first addr", (log_q.size() > 4) ? log_q[4].addr : 32'hFFFF_FFFF, 32'h0000_2000);
        // Response held for 5 cycles with cacheresp_rdy low.
        do_access(1'b0, 32'h0000_2004, 32'h0, 5, "hold rd 2004");

        // Two dirty sets, then a flush that coincides with a request.
        do_access(1'b1, 32'h0000_2000, 32'h1111_2222, 0, "wr 2000");
        do_access(1'b1, 32'h0000_1050, 32'h3333_4444, 0, "wr 1050");
        do_flush(1'b1, 32'h0000_1050, "flush+req");

        // Reset during a refill, then the same address misses again.
        log_q.delete();
        cpu_drive(1'b0, 32'h0000_3000, 32'h0);
        n = 0;
        while (!cachereq_rdy && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 cachereq_val = 1'b0;
        n = 0;
        while (!memresp_rdy && n < 200) begin @(negedge clk); n++; end
        check("reached refill resp", memresp_rdy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("mid-miss rst memreq_val",   memreq_val,    1'b0);
        check("mid-miss rst memresp_rdy",  memresp_rdy,   1'b0);
        check("mid-miss rst cachereq_rdy", cachereq_rdy,  1'b0);
        check("mid-miss rst resp_val",     cacheresp_val, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Miss, hit, hit after reset: statistics.
        do_access(1'b0, 32'h0000_3000, 32'h0, 0, "post-rst rd 3000");
        do_access(1'b0, 32'h0000_3000, 32'h0, 0, "rd 3000 again");
        do_access(1'b1, 32'h0000_3004, 32'h5555_6666, 0, "wr 3004");
        check_stats("miss-hit-hit");

        // Random mix over a few sets with conflicting tags.
        for (int i = 0; i < 80; i++) begin
            a = (32'($urandom_range(1, 4)) << 12) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            do_access(1'($urandom_range(0, 1)), a, $urandom, 0, $sformatf("rnd%0d", i));
        end
        check_stats("random");

        // Final flush: memory must then hold every written value.
        do_flush(1'b0, 32'h0, "final flush");
        foreach (shadow[k])
            check($sformatf("mem %h", k), mem_read(k), shadow[k]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
